// File: rtl/rosc_pkg.sv
// Shared constants and phase-state type for the trimmable ring-oscillator model.
package rosc_pkg;

    localparam int unsigned ROSC_NSTAGES = 13;
    localparam int unsigned ROSC_TRIM_W  = 26;
    localparam int unsigned ROSC_UNITS_W = 5;

    // Quadrature phase state; the encoding is {clockp[1], clockp[0]}.
    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_01 = 2'b01,
        PH_11 = 2'b11,
        PH_10 = 2'b10
    } rosc_phase_e;

    // Gray-ordered successor: exactly one output bit toggles per step.
    function automatic rosc_phase_e rosc_next_phase(input rosc_phase_e p);
        rosc_phase_e n;
        case (p)
            PH_00:   n = PH_01;
            PH_01:   n = PH_11;
            PH_11:   n = PH_10;
            default: n = PH_00;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rosc_trim_model_if.sv
// Trim/clock bundle between the oscillator model and its user.
interface rosc_trim_model_if;
    import rosc_pkg::*;

    logic [ROSC_TRIM_W-1:0]  trim;
    logic [1:0]              clockp;
    logic [ROSC_UNITS_W-1:0] trim_units;

    modport master (output trim, input clockp, input trim_units);
    modport slave  (input trim, output clockp, output trim_units);
endinterface

// File: rtl/rosc_trim_decode.sv
// Trim decode: 26-bit trim word -> effective units, and registered units -> half-period.
module rosc_trim_decode
    import rosc_pkg::*;
#(
    parameter int unsigned BASE_HALF = 4,
    parameter int unsigned STEP      = 1,
    parameter int unsigned CNT_W     = 5
) (
    input  logic [ROSC_TRIM_W-1:0]  trim,
    input  logic [ROSC_UNITS_W-1:0] units,
    output logic [ROSC_UNITS_W-1:0] units_c,
    output logic [CNT_W-1:0]        half_c
);

    // Primary bit counts once; a secondary bit only adds when its primary is set.
    always_comb begin
        units_c = '0;
        for (int i = 0; i < int'(ROSC_NSTAGES); i++) begin
            units_c = units_c
                    + ROSC_UNITS_W'(trim[i])
                    + ROSC_UNITS_W'(trim[i] & trim[i + int'(ROSC_NSTAGES)]);
        end
    end

    // Half-phase length in clk cycles for the given unit count.
    always_comb begin
        half_c = CNT_W'(BASE_HALF) + CNT_W'(STEP) * CNT_W'(units);
    end

endmodule

// File: rtl/rosc_trim_model.sv
// Clock-driven model of the 13-stage trimmable ring oscillator.
// Optional feature macro: ROSC_GLITCHFREE_EN (latch the half-period only at phase
// steps and on restart, so trim changes never disturb the half-phase in progress).
module rosc_trim_model
    import rosc_pkg::*;
#(
    parameter int unsigned BASE_HALF = 4,
    parameter int unsigned STEP      = 1
) (
    input  logic                clk,
    input  logic                resetb,
    input  logic                reset,
    rosc_trim_model_if.slave    bus
);

    localparam int unsigned CNT_W = $clog2(BASE_HALF + ROSC_TRIM_W * STEP + 1);

    logic [ROSC_UNITS_W-1:0] units_c;
    logic [ROSC_UNITS_W-1:0] units_q;
    logic [CNT_W-1:0]        half_c;
    logic [CNT_W-1:0]        h_eff;
    logic [CNT_W-1:0]        cnt_q;
    logic                    wrap_c;
    rosc_phase_e             phase_q;

    rosc_trim_decode #(
        .BASE_HALF (BASE_HALF),
        .STEP      (STEP),
        .CNT_W     (CNT_W)
    ) u_decode (
        .trim    (bus.trim),
        .units   (units_q),
        .units_c (units_c),
        .half_c  (half_c)
    );

`ifdef ROSC_GLITCHFREE_EN
    logic [CNT_W-1:0] h_q;
    logic             run_q;

    // Half-period latch: tracks the live value while stopped, then only at wraps.
    always_ff @(posedge clk) begin
        if (!resetb || reset) begin
            h_q   <= half_c;
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (!run_q || wrap_c) begin
                h_q <= half_c;
            end
        end
    end

    assign h_eff = h_q;
`else
    assign h_eff = half_c;
`endif

    // A counter beyond the new terminal value (trim shrink) wraps immediately.
    assign wrap_c = (cnt_q >= (h_eff - CNT_W'(1)));

    // Trim-unit register, half-phase counter and quadrature phase FSM.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            units_q <= '0;
            cnt_q   <= '0;
            phase_q <= PH_00;
        end else begin
            units_q <= units_c;
            if (reset) begin
                cnt_q   <= '0;
                phase_q <= PH_00;
            end else if (wrap_c) begin
                cnt_q   <= '0;
                phase_q <= rosc_next_phase(phase_q);
            end else begin
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.clockp     = 2'(phase_q);
    assign bus.trim_units = units_q;

endmodule

// File: tb/tb_rosc_trim_model.sv
// Scoreboard bench for rosc_trim_model: stimulus queues expected phase steps and
// register probes; a negedge monitor pops and compares them.
module tb_rosc_trim_model;
    import rosc_pkg::*;

    typedef struct {
        logic [1:0]  val;
        int unsigned cyc;
    } step_t;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  cp;
        logic [4:0]  units;
    } probe_t;

    logic clk    = 1'b0;
    logic resetb = 1'b0;
    logic reset  = 1'b0;

    rosc_trim_model_if bus ();

    rosc_trim_model #(.BASE_HALF(4), .STEP(1)) dut (
        .clk    (clk),
        .resetb (resetb),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    step_t  step_q[$];
    probe_t probe_q[$];
    int     tests = 0;
    int     fails = 0;
    bit     done  = 1'b0;
    logic [1:0] last_cp = 2'b00;

    function automatic logic [1:0] next_val(input logic [1:0] v);
        case (v)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Monitor: compare each clockp change and each scheduled probe against the queues.
    always @(negedge clk) begin
        step_t  s;
        probe_t p;
        if (bus.clockp != last_cp) begin
            tests++;
            if (step_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_step: clockp=%b at cycle %0d, no step expected", bus.clockp, cyc);
            end else begin
                s = step_q.pop_front();
                if (bus.clockp !== s.val || cyc != s.cyc) begin
                    fails++;
                    $display("FAIL phase_step: got clockp=%b at cycle %0d, expected %b at cycle %0d",
                             bus.clockp, cyc, s.val, s.cyc);
                end
            end
            last_cp = bus.clockp;
        end
        if (step_q.size() > 0 && step_q[0].cyc < cyc) begin
            s = step_q.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_step: expected clockp=%b at cycle %0d, still %b at cycle %0d",
                     s.val, s.cyc, bus.clockp, cyc);
        end
        while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
            p = probe_q.pop_front();
            tests++;
            if (p.cyc != cyc || bus.clockp !== p.cp || bus.trim_units !== p.units) begin
                fails++;
                $display("FAIL probe: cycle %0d got clockp=%b units=%0d, expected clockp=%b units=%0d (cycle %0d)",
                         cyc, bus.clockp, bus.trim_units, p.cp, p.units, p.cyc);
            end
        end
        if (done) begin
            tests++;
            if (step_q.size() != 0 || probe_q.size() != 0) begin
                fails++;
                $display("FAIL leftover: %0d steps and %0d probes never seen, expected 0",
                         step_q.size(), probe_q.size());
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    task automatic push_probe(input int unsigned c, input logic [1:0] cp, input logic [4:0] u);
        probe_t p;
        p.cyc = c; p.cp = cp; p.units = u;
        probe_q.push_back(p);
    endtask

    task automatic push_steps(input int unsigned start, input int unsigned h, input int n);
        step_t s;
        logic [1:0] v = 2'b00;
        for (int k = 1; k <= n; k++) begin
            v     = next_val(v);
            s.val = v;
            s.cyc = start + int'(k) * h;
            step_q.push_back(s);
        end
    endtask

    // Settle a trim while held, release, and expect n steps of h cycles each.
    task automatic run_segment(input logic [25:0] t, input int unsigned h,
                               input logic [4:0] u, input int n);
        int unsigned r;
        bus.trim = t;
        repeat (2) @(negedge clk);
        r = cyc;
        push_probe(r + 1, 2'b00, u);
        push_steps(r, h, n);
        reset = 1'b0;
        repeat (int'(h) * n) @(negedge clk);
        reset = 1'b1;
    endtask

    // Stimulus.
    initial begin
        int unsigned r;
        step_t s;
        bus.trim = 26'h3FFFFFF;
        push_probe(2, 2'b00, 5'd0);
        repeat (2) @(negedge clk);
        resetb = 1'b1;
        reset  = 1'b1;
        push_probe(3, 2'b00, 5'd26);
        @(negedge clk);

        run_segment(26'h0000000, 4, 5'd0, 8);
        run_segment(26'h3FFE000, 4, 5'd0, 4);
        run_segment(26'h0000001, 5, 5'd1, 4);
        run_segment(26'h0002001, 6, 5'd2, 4);
        run_segment(26'h3FFFFFF, 30, 5'd26, 4);

        // Hold mid-period, then restart counting from zero.
        bus.trim = 26'h0;
        repeat (2) @(negedge clk);
        r = cyc;
        push_steps(r, 4, 1);
        s.val = 2'b00; s.cyc = r + 7;
        step_q.push_back(s);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        r = cyc;
        push_steps(r, 4, 4);
        reset = 1'b0;
        repeat (16) @(negedge clk);
        reset = 1'b1;

        // Trim switch 0 -> max while the counter is at 1.
        bus.trim = 26'h0;
        repeat (2) @(negedge clk);
        r = cyc;
`ifdef ROSC_GLITCHFREE_EN
        s.val = 2'b01; s.cyc = r + 4;
        step_q.push_back(s);
        push_probe(r + 2, 2'b00, 5'd26);
        s.val = 2'b11; s.cyc = r + 34;  step_q.push_back(s);
        s.val = 2'b10; s.cyc = r + 64;  step_q.push_back(s);
        s.val = 2'b00; s.cyc = r + 94;  step_q.push_back(s);
`else
        push_probe(r + 2, 2'b00, 5'd26);
        push_steps(r, 30, 4);
`endif
        reset = 1'b0;
        @(negedge clk);
        bus.trim = 26'h3FFFFFF;
`ifdef ROSC_GLITCHFREE_EN
        repeat (93) @(negedge clk);
`else
        repeat (119) @(negedge clk);
`endif
        reset = 1'b1;
        repeat (3) @(negedge clk);
        done = 1'b1;
        repeat (10) @(negedge clk);
        $display("FAIL monitor_stall: summary not reached, expected finish");
        $fatal(1);
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
